// File: rtl/hello_gen_fsm_module.sv
// Emits the ASCII word "Hello" a programmable number of times on an 8-bit valid/ready stream.
// All outputs are registered and derived from the next state, so they change one edge after a decision.
module hello_gen_fsm_module #(
  parameter int unsigned REPEAT_W   = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start_in,
  input  logic [REPEAT_W-1:0] repeat_in,
  output logic [7:0]          data_out,
  output logic                valid_out,
  input  logic                ready_in,
  output logic                busy_out,
  output logic                done_out
);

  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GapW-1:0] GapLast = (GAP_CYCLES > 0) ? GapW'(GAP_CYCLES - 1) : '0;

  localparam logic [7:0] ByteH = 8'h48;
  localparam logic [7:0] ByteE = 8'h65;
  localparam logic [7:0] ByteL = 8'h6C;
  localparam logic [7:0] ByteO = 8'h6F;

  typedef enum logic [7:0] {
    StIdle   = 8'b0000_0001,
    StSendH  = 8'b0000_0010,
    StSendE  = 8'b0000_0100,
    StSendL1 = 8'b0000_1000,
    StSendL2 = 8'b0001_0000,
    StSendO  = 8'b0010_0000,
    StGap    = 8'b0100_0000,
    StDone   = 8'b1000_0000
  } state_e;

  state_e              state_q, state_d;
  logic [REPEAT_W-1:0] words_left_q, words_left_d;
  logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [7:0]          data_q, data_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                xfer;

  assign xfer = valid_q && ready_in;

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    gap_cnt_d    = gap_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          words_left_d = repeat_in;
          gap_cnt_d    = '0;
          state_d      = (repeat_in != '0) ? StSendH : StDone;
        end
      end
      StSendH:  if (xfer) state_d = StSendE;
      StSendE:  if (xfer) state_d = StSendL1;
      StSendL1: if (xfer) state_d = StSendL2;
      StSendL2: if (xfer) state_d = StSendO;
      StSendO: begin
        if (xfer) begin
          words_left_d = words_left_q - REPEAT_W'(1);
          if (words_left_q == REPEAT_W'(1)) begin
            state_d = StDone;
          end else if (GAP_CYCLES > 0) begin
            state_d   = StGap;
            gap_cnt_d = '0;
          end else begin
            state_d = StSendH;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d   = StSendH;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: begin
        // Corrupted one-hot encoding: recover to idle with cleared counters
        state_d      = StIdle;
        words_left_d = '0;
        gap_cnt_d    = '0;
      end
    endcase
  end

  always_comb begin
    data_d  = 8'h00;
    valid_d = 1'b0;
    busy_d  = (state_d != StIdle);
    done_d  = 1'b0;
    case (state_d)
      StSendH:  begin data_d = ByteH; valid_d = 1'b1; end
      StSendE:  begin data_d = ByteE; valid_d = 1'b1; end
      StSendL1: begin data_d = ByteL; valid_d = 1'b1; end
      StSendL2: begin data_d = ByteL; valid_d = 1'b1; end
      StSendO:  begin data_d = ByteO; valid_d = 1'b1; end
      StDone:   done_d = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      words_left_q <= '0;
      gap_cnt_q    <= '0;
      data_q       <= 8'h00;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      gap_cnt_q    <= gap_cnt_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign busy_out  = busy_q;
  assign done_out  = done_q;

endmodule

// File: tb/tb_hello_gen_fsm_module.sv
// Directed bench for the Hello generator: scoreboard of expected bytes plus cycle-exact
// checks of valid/busy/done on a gapped (GAP_CYCLES=2) and a gapless (GAP_CYCLES=0) instance.
module tb_hello_gen_fsm_module;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, ready, busy, done, valid;
  logic [3:0] rep;
  logic [7:0] data;
  logic       start0, ready0, busy0, done0, valid0;
  logic [3:0] rep0;
  logic [7:0] data0;

  always #5 clk = ~clk;

  hello_gen_fsm_module #(.REPEAT_W(4), .GAP_CYCLES(2)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .repeat_in(rep), .data_out(data),
    .valid_out(valid), .ready_in(ready), .busy_out(busy), .done_out(done)
  );

  hello_gen_fsm_module #(.REPEAT_W(4), .GAP_CYCLES(0)) dut_g0 (
    .clk_in(clk), .rst_in(rst), .start_in(start0), .repeat_in(rep0), .data_out(data0),
    .valid_out(valid0), .ready_in(ready0), .busy_out(busy0), .done_out(done0)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         xfer_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] hello_b[5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_words(input int n);
    for (int w = 0; w < n; w++)
      for (int b = 0; b < 5; b++) exp_q.push_back(hello_b[b]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted byte must match the next expected byte
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) check("xfer_extra", 32'(exp_q.size()), 32'd1);
        else check("xfer_byte", 32'(data), 32'(exp_q.pop_front()));
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    int x0, d0;
    rst = 1'b1; start = 1'b0; rep = '0; ready = 1'b0;
    start0 = 1'b0; rep0 = '0; ready0 = 1'b1;
    step(); step();
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    step();

    // Single word, ready held high
    x0 = xfer_cnt; d0 = done_cnt;
    rep = 4'd1; ready = 1'b1; push_words(1); start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 1) start = 1'b0;
      check("t1_valid", 32'(valid), 32'(c <= 5));
      check("t1_busy", 32'(busy), 32'(c <= 6));
      check("t1_done", 32'(done), 32'(c == 6));
    end
    check("t1_xfers", 32'(xfer_cnt - x0), 32'd5);
    check("t1_dones", 32'(done_cnt - d0), 32'd1);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Back-pressure while 'e' is presented
    x0 = xfer_cnt; d0 = done_cnt;
    push_words(1); start = 1'b1;
    step(); start = 1'b0;
    check("t2_h", 32'(data), 32'h48);
    for (int c = 2; c <= 5; c++) begin
      step();
      if (c == 2) ready = 1'b0;
      if (c == 5) ready = 1'b1;
      check("t2_hold_data", 32'(data), 32'h65);
      check("t2_hold_valid", 32'(valid), 32'd1);
    end
    for (int c = 6; c <= 10; c++) begin
      step();
      check("t2_done", 32'(done), 32'(c == 9));
    end
    check("t2_xfers", 32'(xfer_cnt - x0), 32'd5);
    check("t2_dones", 32'(done_cnt - d0), 32'd1);

    // Three words with two gap cycles between them
    x0 = xfer_cnt;
    rep = 4'd3; push_words(3); start = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      step();
      if (c == 1) start = 1'b0;
      check("t3_valid", 32'(valid), 32'((c <= 19) && (((c - 1) % 7) < 5)));
      check("t3_done", 32'(done), 32'(c == 20));
    end
    check("t3_xfers", 32'(xfer_cnt - x0), 32'd15);

    // Starts during SEND_L1 and during DONE are both ignored
    x0 = xfer_cnt;
    rep = 4'd1; push_words(1); start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) start = 1'b0;
      if (c == 3) begin
        check("t4_l1", 32'(data), 32'h6C);
        start = 1'b1; rep = 4'd5;
      end
      if (c == 4) start = 1'b0;
      if (c == 6) start = 1'b1;
      if (c == 7) start = 1'b0;
      check("t4_done", 32'(done), 32'(c == 6));
      check("t4_busy", 32'(busy), 32'(c <= 6));
    end
    check("t4_xfers", 32'(xfer_cnt - x0), 32'd5);

    // Zero repeat count: straight to DONE
    x0 = xfer_cnt;
    rep = 4'd0; start = 1'b1;
    step(); start = 1'b0;
    check("t5_done1", 32'(done), 32'd1);
    check("t5_valid1", 32'(valid), 32'd0);
    check("t5_busy1", 32'(busy), 32'd1);
    step();
    check("t5_done2", 32'(done), 32'd0);
    check("t5_busy2", 32'(busy), 32'd0);
    step();
    check("t5_valid3", 32'(valid), 32'd0);
    check("t5_xfers", 32'(xfer_cnt - x0), 32'd0);

    // Reset while 'l' is valid and ready is high
    rep = 4'd2; push_words(2); start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    check("t6_l1", 32'(data), 32'h6C);
    rst = 1'b1;
    step(); rst = 1'b0;
    exp_q.delete();
    d0 = done_cnt;
    check("t6_valid", 32'(valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_data", 32'(data), 32'h00);
    check("t6_done", 32'(done), 32'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("t6_quiet", 32'(valid), 32'd0);
    end
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    rep = 4'd1; push_words(1); start = 1'b1;
    step(); start = 1'b0;
    check("t6_restart_h", 32'(data), 32'h48);
    check("t6_restart_v", 32'(valid), 32'd1);
    for (int c = 2; c <= 7; c++) begin
      step();
      check("t6_restart_done", 32'(done), 32'(c == 6));
    end
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    // Gapless build: two words back to back
    rep0 = 4'd2; start0 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 1) start0 = 1'b0;
      check("t7_valid", 32'(valid0), 32'(c <= 10));
      if (c <= 10) check("t7_data", 32'(data0), 32'(hello_b[(c - 1) % 5]));
      check("t7_done", 32'(done0), 32'(c == 11));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
